// File: rtl/data_ram_bridge_pkg.sv
// Shared definitions for the CPU data-port to external-memory bridge:
// bus widths, FSM encoding, timeout default and request layout.
package data_ram_bridge_pkg;

  localparam int unsigned RegWidth       = 32;
  localparam int unsigned StrbWidth      = RegWidth / 8;
  localparam int unsigned CntWidth       = 8;
  localparam int unsigned DefaultTimeout = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [RegWidth-1:0]  addr;
    logic [RegWidth-1:0]  wdata;
    logic [StrbWidth-1:0] sel;
  } req_t;

  function automatic logic [RegWidth-1:0] word_align(input logic [RegWidth-1:0] a);
    return {a[RegWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/data_ram_bridge.sv
// Stalls the CPU data port while one load/store is forwarded to external
// memory; completes on ext_ack or aborts with a sticky bus_err on timeout.
module data_ram_bridge
  import data_ram_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sel,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wstrb,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        bus_err
);

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [RegWidth-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                timeout_s;

  assign timeout_s = (cnt_q == CntWidth'(TIMEOUT - 1));

  // Next state and datapath updates for the IDLE -> REQ -> DONE handshake.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cpu_en) begin
          req_d   = '{we: cpu_we, addr: word_align(cpu_addr), wdata: cpu_wdata, sel: cpu_sel};
          cnt_d   = {CntWidth{1'b0}};
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack in the final wait cycle still completes normally.
        if (ext_ack) begin
          if (!req_q.we) begin
            rdata_d = ext_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = DONE;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          rdata_d = {RegWidth{1'b0}};
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CntWidth'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request, counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '{we: 1'b0, addr: 32'h0000_0000, wdata: 32'h0000_0000, sel: 4'b0000};
      cnt_q   <= {CntWidth{1'b0}};
      rdata_q <= {RegWidth{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Gated by rst so a held cpu_en cannot stall the CPU during reset.
  assign cpu_stall = rst & (((state_q == IDLE) & cpu_en) | (state_q == REQ));
  assign ext_req   = (state_q == REQ);
  assign ext_we    = req_q.we;
  assign ext_addr  = req_q.addr;
  assign ext_wdata = req_q.wdata;
  assign ext_wstrb = req_q.sel;
  assign cpu_rdata = rdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_data_ram_bridge.sv
// Scoreboard bench for data_ram_bridge: a CPU-like driver queues expected
// transactions from a reference model; a monitor checks each ext_req burst.
module tb_data_ram_bridge;

  localparam int TB_TIMEOUT = 6;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_wstrb;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        bus_err;

  data_ram_bridge #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_sel   (cpu_sel),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_wstrb (ext_wstrb),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          n_req;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err = 1'b0;

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %b required %b", name, act, req);
    end
  endfunction

  // One CPU access; ack_cyc = REQ cycle carrying ext_ack (0 or > TIMEOUT: none),
  // rst_cyc = REQ cycle at which reset is asserted (0: never).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int ack_cyc, input logic [31:0] ack_data,
                           input int rst_cyc);
    exp_t e;
    int   c;
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_sel = sel;
    e.we = we; e.addr = addr & 32'hFFFF_FFFC; e.wdata = wdata; e.sel = sel;
    if (ack_cyc >= 1 && ack_cyc <= TB_TIMEOUT) begin
      e.n_req = ack_cyc;
      if (!we) m_rdata = ack_data;
    end else begin
      e.n_req = TB_TIMEOUT;
      m_rdata = 32'h0;
      m_err   = 1'b1;
    end
    e.rdata = m_rdata;
    e.err   = m_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    c = 1;
    while (ext_req && c <= TB_TIMEOUT + 1) begin
      if (c == rst_cyc) begin
        rst = 1'b0;
        #1;
        chk1("rst_drops_ext_req", ext_req, 1'b0);
        chk1("rst_drops_stall", cpu_stall, 1'b0);
        m_rdata = 32'h0;
        m_err   = 1'b0;
        break;
      end
      ext_ack   = (c == ack_cyc);
      ext_rdata = ext_ack ? ack_data : $urandom;
      @(posedge clk); #1;
      ext_ack   = 1'b0;
      ext_rdata = $urandom;
      c++;
    end
    chk1("req_bound", ext_req, 1'b0);
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cpu_en = 1'b0;
    end
  endtask

  // Monitor: pops an expectation whenever ext_req rises, checks it when ext_req falls.
  exp_t cur;
  logic req_prev = 1'b0;
  logic active = 1'b0;
  logic stable_ok = 1'b1;
  int   n_req = 0;
  int   stall_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_prev  = 1'b0;
        active    = 1'b0;
        stall_cnt = 0;
      end else begin
        if (cpu_stall) stall_cnt++;
        if (ext_req && !req_prev) begin
          if (exp_q.size() == 0) begin
            chk1("unexpected_ext_req", ext_req, 1'b0);
            active = 1'b0;
          end else begin
            cur       = exp_q.pop_front();
            active    = 1'b1;
            n_req     = 1;
            stable_ok = 1'b1;
            chk1("ext_we", ext_we, cur.we);
            chk32("ext_addr", ext_addr, cur.addr);
            chk32("ext_wdata", ext_wdata, cur.wdata);
            chk32("ext_wstrb", 32'(ext_wstrb), 32'(cur.sel));
          end
        end else if (ext_req && req_prev) begin
          n_req++;
          if (active && (ext_we !== cur.we || ext_addr !== cur.addr ||
                         ext_wdata !== cur.wdata || ext_wstrb !== cur.sel))
            stable_ok = 1'b0;
        end else if (!ext_req && req_prev && active) begin
          chk32("req_cycles", 32'(n_req), 32'(cur.n_req));
          chk32("stall_cycles", 32'(stall_cnt), 32'(cur.n_req + 1));
          chk1("done_stall", cpu_stall, 1'b0);
          chk32("cpu_rdata", cpu_rdata, cur.rdata);
          chk1("bus_err", bus_err, cur.err);
          chk1("req_stable", stable_ok, 1'b1);
          active    = 1'b0;
          stall_cnt = 0;
        end
        req_prev = ext_req;
      end
    end
  end

  initial begin
    rst = 1'b0; cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0004;
    cpu_wdata = 32'h0; cpu_sel = 4'hF; ext_ack = 1'b0; ext_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_stall", cpu_stall, 1'b0);
    chk1("reset_ext_req", ext_req, 1'b0);
    chk32("reset_rdata", cpu_rdata, 32'h0);
    chk1("reset_bus_err", bus_err, 1'b0);
    chk32("reset_ext_addr", ext_addr, 32'h0);
    chk32("reset_ext_wstrb", 32'(ext_wstrb), 32'h0);
    cpu_en = 1'b0;
    rst    = 1'b1;
    idle_gap(2);

    do_access(1'b0, 32'h1000_0006, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 0);
    chk32("load_rdata_in_done", cpu_rdata, 32'hCAFE_F00D);
    do_access(1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011, 5, 32'h5555_AAAA, 0);
    chk32("store_holds_rdata", cpu_rdata, 32'hCAFE_F00D);

    // ext_ack while idle must be ignored.
    @(posedge clk); #1;
    cpu_en = 1'b0; ext_ack = 1'b1; ext_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    chk32("idle_ack_rdata", cpu_rdata, m_rdata);
    chk1("idle_ack_no_req", ext_req, 1'b0);
    chk1("idle_ack_no_stall", cpu_stall, 1'b0);

    do_access(1'b0, 32'h3000_0008, 32'h0, 4'hF, TB_TIMEOUT, 32'h0BAD_F00D, 0);
    chk1("ack_at_timeout_no_err", bus_err, 1'b0);
    do_access(1'b0, 32'h4000_000C, 32'h0, 4'hF, 0, 32'h0, 0);
    do_access(1'b0, 32'h4000_0010, 32'h0, 4'hF, 2, 32'h7777_1234, 0);
    chk1("bus_err_sticky", bus_err, 1'b1);

    for (int i = 0; i < 150; i++) begin
      do_access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(TB_TIMEOUT + 1, TB_TIMEOUT + 2))
                                            : int'($urandom_range(1, TB_TIMEOUT)),
                $urandom, 0);
      if ($urandom_range(0, 2) == 0) idle_gap(int'($urandom_range(1, 3)));
    end

    // Reset in the second REQ cycle, then a stray ack after release.
    do_access(1'b0, 32'h5000_0020, 32'h0, 4'hF, 0, 32'h0, 2);
    repeat (2) @(posedge clk);
    #1;
    cpu_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    ext_ack = 1'b1; ext_rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    chk32("post_reset_rdata", cpu_rdata, 32'h0);
    chk1("post_reset_bus_err", bus_err, 1'b0);
    chk1("post_reset_no_req", ext_req, 1'b0);

    do_access(1'b0, 32'h6000_0001, 32'h0, 4'hF, 3, 32'h1357_9BDF, 0);
    idle_gap(3);
    chk32("queue_empty", 32'(exp_q.size()), 32'h0);
    chk1("monitor_idle", active, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
